// File: rtl/mem_pkg.sv
// Shared memory-map constants and the posted-write entry type used by the
// on-chip SRAM controller.
package mem_pkg;

  localparam logic [3:0] REGION_SRAM = 4'h0;
  localparam logic [3:0] REGION_VRAM = 4'h8;
  localparam logic [3:0] REGION_CTRL = 4'hF;

  localparam int unsigned REGION_BITS = 4;
  localparam int unsigned WORD_LSB    = 0;
  localparam int unsigned WORD_BITS   = 8;
  localparam int unsigned BANK_LSB    = 8;

  // Entries are sized for the widest supported port; narrower instances
  // zero-extend on push and slice on pop.
  localparam int unsigned ENTRY_AW = 32;
  localparam int unsigned ENTRY_DW = 32;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [ENTRY_DW-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sram_bank.sv
// One 256-word bank with synchronous write and registered, read-first read;
// shaped to map onto an SB_RAM256x16 primitive.
module sram_bank
  import mem_pkg::*;
#(
  parameter int unsigned DWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [WORD_BITS-1:0] waddr,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic                 re,
  input  logic [WORD_BITS-1:0] raddr,
  output logic [DWIDTH-1:0]    rdata
);

  logic [DWIDTH-1:0] mem_q [1 << WORD_BITS];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_sram_ctrl.sv
// Banked SRAM controller: prioritised debug/CPU write ports with a posted
// CPU write FIFO, and a single registered CPU read port.
module banked_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned AWIDTH    = 16,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned BANK_BITS = 1,
  parameter logic [3:0]  REGION    = REGION_SRAM,
  parameter int unsigned WQ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dbg_we,
  input  logic [AWIDTH-1:0] dbg_waddr,
  input  logic [DWIDTH-1:0] dbg_wdata,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_waddr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_wfull,
  input  logic              cpu_re,
  input  logic [AWIDTH-1:0] cpu_raddr,
  output logic              cpu_rstall,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              wdrop
);

  localparam int unsigned NBANKS = 1 << BANK_BITS;
  localparam int unsigned BSEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int unsigned PTR_W  = $clog2(WQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  function automatic logic in_region(input logic [AWIDTH-1:0] a);
    return a[AWIDTH-1 -: REGION_BITS] == REGION;
  endfunction

  function automatic logic [BSEL_W-1:0] bank_of(input logic [AWIDTH-1:0] a);
    if (BANK_BITS == 0) return '0;
    return a[BANK_LSB +: BSEL_W];
  endfunction

  wr_entry_t         wq_mem_q [WQ_DEPTH];
  wr_entry_t         head, push_entry;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wdrop_q, wdrop_d;
  logic              rvalid_q, rvalid_d;
  logic              rd_inreg_q, rd_inreg_d;
  logic [BSEL_W-1:0] rd_bank_q, rd_bank_d;

  logic              wq_empty, wq_full, push, pop, direct, drop, rd_accept;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_waddr, head_addr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [NBANKS-1:0] bank_we;
  logic [DWIDTH-1:0] bank_rdata [NBANKS];

  always_comb begin
    wq_empty   = (count_q == '0);
    wq_full    = (count_q == CNT_W'(WQ_DEPTH));
    head       = wq_mem_q[rd_ptr_q];
    head_addr  = head.addr[AWIDTH-1:0];
    push_entry = '{addr: ENTRY_AW'(cpu_waddr), data: ENTRY_DW'(cpu_wdata)};
    ram_we     = 1'b0;
    ram_waddr  = dbg_waddr;
    ram_wdata  = dbg_wdata;
    pop        = 1'b0;
    direct     = 1'b0;

    // An out-of-region debug write still owns the RAM port for the cycle.
    if (dbg_we) begin
      ram_we = in_region(dbg_waddr);
    end else if (!wq_empty) begin
      pop       = 1'b1;
      ram_we    = in_region(head_addr);
      ram_waddr = head_addr;
      ram_wdata = head.data[DWIDTH-1:0];
    end else if (cpu_we) begin
      direct    = 1'b1;
      ram_we    = in_region(cpu_waddr);
      ram_waddr = cpu_waddr;
      ram_wdata = cpu_wdata;
    end

    push = cpu_we && !direct && !wq_full;
    drop = cpu_we && wq_full;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wdrop_d  = wdrop_q | drop;

    bank_we = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      bank_we[b] = ram_we && (bank_of(ram_waddr) == BSEL_W'(b));
    end

    rd_accept  = cpu_re && wq_empty;
    rvalid_d   = rd_accept;
    rd_inreg_d = rd_accept ? in_region(cpu_raddr) : rd_inreg_q;
    rd_bank_d  = rd_accept ? bank_of(cpu_raddr) : rd_bank_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wdrop_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rd_inreg_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wdrop_q    <= wdrop_d;
      rvalid_q   <= rvalid_d;
      rd_inreg_q <= rd_inreg_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) wq_mem_q[wr_ptr_q] <= push_entry;
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    sram_bank #(.DWIDTH(DWIDTH)) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (ram_waddr[WORD_LSB +: WORD_BITS]),
      .wdata (ram_wdata),
      .re    (rd_accept),
      .raddr (cpu_raddr[WORD_LSB +: WORD_BITS]),
      .rdata (bank_rdata[g])
    );
  end

  // Bank outputs only change on an accepted read, and rd_inreg_q resets low,
  // so this mux both holds the last result and reads zero out of reset.
  assign cpu_rdata  = rd_inreg_q ? bank_rdata[rd_bank_q] : '0;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rstall = cpu_re && !wq_empty;
  assign cpu_wfull  = wq_full;
  assign wdrop      = wdrop_q;

  // Aliased address bits and the unused upper entry bits are ignored.
  logic unused_bits;
  assign unused_bits = ^{dbg_waddr, cpu_waddr, cpu_raddr, head.addr, head.data};

endmodule
